// File: rtl/hf_req_scheduler_if.sv
// Purpose: bundles the requester, encoder and response signals of hf_req_scheduler.
// Latency: none; this file only declares wires.
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready carry valid/ready flow control.
// Ports (slave = scheduler view):
//   req_valid/req_freq in, req_ready out   - per-requester frame handshake
//   enc_freq/enc_start out, enc_code in     - shared encoder core
//   rsp_valid/rsp_code/rsp_id out, rsp_ready in, busy out
interface hf_req_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*25-1:0] req_freq;
    logic [NUM_REQ-1:0]    req_ready;
    logic [24:0]           enc_freq;
    logic                  enc_start;
    logic [19:0]           enc_code;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [19:0]           rsp_code;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;

    // Environment side: frame sources, encoder core and result consumer.
    modport master (
        output req_valid, req_freq, enc_code, rsp_ready,
        input  req_ready, enc_freq, enc_start, rsp_valid, rsp_code, rsp_id, busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_freq, enc_code, rsp_ready,
        output req_ready, enc_freq, enc_start, rsp_valid, rsp_code, rsp_id, busy
    );
endinterface

// File: rtl/hf_req_scheduler.sv
// Purpose: round-robin share of one Huffman encoder core among NUM_REQ frame requesters.
// Latency: rsp_valid rises ENC_LAT+1 cycles after the accept; one job per ENC_LAT+2 cycles minimum.
// Backpressure: one job in flight; result held in RESP until rsp_ready, requesters stalled meanwhile.
// Ports: clk, rst (async active-high), bus (hf_req_scheduler_if.slave) carrying
//   req_valid/req_freq/req_ready, enc_freq/enc_start/enc_code, rsp_valid/rsp_ready/rsp_code/rsp_id, busy.
module hf_req_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ENC_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    hf_req_scheduler_if.slave   bus
);
    localparam int CNT_W = (ENC_LAT < 2) ? 1 : $clog2(ENC_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt;
    logic [24:0]      enc_freq_q;
    logic             enc_start_q;
    logic             rsp_valid_q;
    logic [19:0]      rsp_code_q;
    logic [ID_W-1:0]  rsp_id_q;

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [24:0]      grant_freq;
    logic             accept;
    logic [NUM_REQ-1:0] ready_vec;

    // Round-robin search: first pass covers ptr..NUM_REQ-1, second pass wraps
    // to 0..ptr-1. Only constant indices are used, so out-of-range ids never appear.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_found && (j >= int'(ptr)) && bus.req_valid[j]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!grant_found && (j < int'(ptr)) && bus.req_valid[j]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(j);
            end
        end
    end

    // Grant is only offered in IDLE and never while reset is asserted.
    assign accept = (state == IDLE) && grant_found && !rst;

    always_comb begin
        ready_vec  = '0;
        grant_freq = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_idx == ID_W'(j)) begin
                ready_vec[j] = accept;
                grant_freq   = bus.req_freq[25*j +: 25];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers. enc_freq is left untouched after a response so the
    // encoder input only changes on a new accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            cnt         <= '0;
            enc_freq_q  <= '0;
            enc_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            enc_start_q <= accept;
            case (state)
                IDLE: begin
                    if (accept) begin
                        enc_freq_q <= grant_freq;
                        rsp_id_q   <= grant_idx;
                        cnt        <= CNT_W'(ENC_LAT);
                        ptr        <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        rsp_code_q  <= bus.enc_code;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.enc_freq  = enc_freq_q;
    assign bus.enc_start = enc_start_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_code  = rsp_code_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state != IDLE);
endmodule
